// File: rtl/add_resv_station.sv
// rtl/add_resv_station.sv - FP add/sub reservation station with CDB snoop and dispatch
module add_resv_station #(
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 3,
  parameter int NUM_ENT  = 3,
  parameter int BASE_TAG = 1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              issue_valid,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic [1:0]        issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] CDB,
  input  logic              fu_ready,
  output logic              disp_valid,
  output logic [DATA_W-1:0] resv_out1,
  output logic [DATA_W-1:0] resv_out2,
  output logic [1:0]        OP,
  output logic [TAG_W-1:0]  disp_tag
);

  localparam int IDX_W = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;

  typedef enum logic [1:0] {FREE, WAIT, READY, EXEC} ent_state_t;

  ent_state_t        st_r   [NUM_ENT];
  ent_state_t        st_n   [NUM_ENT];
  logic [1:0]        op_r   [NUM_ENT];
  logic [1:0]        op_n   [NUM_ENT];
  logic [DATA_W-1:0] vj_r   [NUM_ENT];
  logic [DATA_W-1:0] vj_n   [NUM_ENT];
  logic [DATA_W-1:0] vk_r   [NUM_ENT];
  logic [DATA_W-1:0] vk_n   [NUM_ENT];
  logic [TAG_W-1:0]  qj_r   [NUM_ENT];
  logic [TAG_W-1:0]  qj_n   [NUM_ENT];
  logic [TAG_W-1:0]  qk_r   [NUM_ENT];
  logic [TAG_W-1:0]  qk_n   [NUM_ENT];

  logic             alloc_any;
  logic [IDX_W-1:0] alloc_idx;
  logic             ready_any;
  logic [IDX_W-1:0] ready_idx;
  logic             issue_fire;
  logic             disp_fire;

  // Lowest-index FREE and READY entries, from registered state only.
  always_comb begin
    alloc_any = 1'b0;
    alloc_idx = '0;
    ready_any = 1'b0;
    ready_idx = '0;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (st_r[i] == FREE) begin
        alloc_any = 1'b1;
        alloc_idx = IDX_W'(i);
      end
      if (st_r[i] == READY) begin
        ready_any = 1'b1;
        ready_idx = IDX_W'(i);
      end
    end
  end

  assign issue_ready = alloc_any;
  assign issue_tag   = alloc_any ? TAG_W'(BASE_TAG + int'(alloc_idx)) : '0;
  assign issue_fire  = issue_valid && alloc_any;
  assign disp_fire   = fu_ready && ready_any;

  // Per-entry next state: issue with bypass, capture, dispatch, release.
  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) begin
      st_n[i] = st_r[i];
      op_n[i] = op_r[i];
      vj_n[i] = vj_r[i];
      vk_n[i] = vk_r[i];
      qj_n[i] = qj_r[i];
      qk_n[i] = qk_r[i];
      case (st_r[i])
        FREE: begin
          if (issue_fire && alloc_idx == IDX_W'(i)) begin
            op_n[i] = issue_op;
            vj_n[i] = issue_vj;
            vk_n[i] = issue_vk;
            qj_n[i] = issue_qj;
            qk_n[i] = issue_qk;
            if (cdb_valid && issue_qj != '0 && cdb_tag == issue_qj) begin
              vj_n[i] = CDB;
              qj_n[i] = '0;
            end
            if (cdb_valid && issue_qk != '0 && cdb_tag == issue_qk) begin
              vk_n[i] = CDB;
              qk_n[i] = '0;
            end
            st_n[i] = (qj_n[i] == '0 && qk_n[i] == '0) ? READY : WAIT;
          end
        end
        WAIT: begin
          if (cdb_valid && cdb_tag != '0 && qj_r[i] == cdb_tag) begin
            vj_n[i] = CDB;
            qj_n[i] = '0;
          end
          if (cdb_valid && cdb_tag != '0 && qk_r[i] == cdb_tag) begin
            vk_n[i] = CDB;
            qk_n[i] = '0;
          end
          if (qj_n[i] == '0 && qk_n[i] == '0) st_n[i] = READY;
        end
        READY: begin
          if (disp_fire && ready_idx == IDX_W'(i)) st_n[i] = EXEC;
        end
        EXEC: begin
          if (cdb_valid && cdb_tag == TAG_W'(BASE_TAG + i)) st_n[i] = FREE;
        end
        default: st_n[i] = FREE;
      endcase
    end
  end

  // Entry storage register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        st_r[i] <= FREE;
        op_r[i] <= '0;
        vj_r[i] <= '0;
        vk_r[i] <= '0;
        qj_r[i] <= '0;
        qk_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENT; i++) begin
        st_r[i] <= st_n[i];
        op_r[i] <= op_n[i];
        vj_r[i] <= vj_n[i];
        vk_r[i] <= vk_n[i];
        qj_r[i] <= qj_n[i];
        qk_r[i] <= qk_n[i];
      end
    end
  end

  // Dispatch register toward the adder; data holds when nothing is sent.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      disp_valid <= 1'b0;
      resv_out1  <= '0;
      resv_out2  <= '0;
      OP         <= '0;
      disp_tag   <= '0;
    end else if (disp_fire) begin
      disp_valid <= 1'b1;
      resv_out1  <= vj_r[ready_idx];
      resv_out2  <= vk_r[ready_idx];
      OP         <= op_r[ready_idx];
      disp_tag   <= TAG_W'(BASE_TAG + int'(ready_idx));
    end else begin
      disp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_resv_station.sv
// tb/tb_add_resv_station.sv - directed self-checking bench for add_resv_station
module tb_add_resv_station;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_tag;
  logic [1:0]  issue_op;
  logic [15:0] issue_vj;
  logic [15:0] issue_vk;
  logic [2:0]  issue_qj;
  logic [2:0]  issue_qk;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] CDB;
  logic        fu_ready;
  logic        disp_valid;
  logic [15:0] resv_out1;
  logic [15:0] resv_out2;
  logic [1:0]  OP;
  logic [2:0]  disp_tag;

  int checks = 0;
  int errors = 0;

  add_resv_station dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_tag   (issue_tag),
    .issue_op    (issue_op),
    .issue_vj    (issue_vj),
    .issue_vk    (issue_vk),
    .issue_qj    (issue_qj),
    .issue_qk    (issue_qk),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .CDB         (CDB),
    .fu_ready    (fu_ready),
    .disp_valid  (disp_valid),
    .resv_out1   (resv_out1),
    .resv_out2   (resv_out2),
    .OP          (OP),
    .disp_tag    (disp_tag)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [1:0] op, input logic [15:0] vj,
                           input logic [15:0] vk, input logic [2:0] qj, input logic [2:0] qk);
    issue_valid = v;
    issue_op    = op;
    issue_vj    = vj;
    issue_vk    = vk;
    issue_qj    = qj;
    issue_qk    = qk;
  endtask

  task automatic set_cdb(input logic v, input logic [2:0] t, input logic [15:0] d);
    cdb_valid = v;
    cdb_tag   = t;
    CDB       = d;
  endtask

  task automatic check_disp(input string tag, input logic [15:0] o1, input logic [15:0] o2,
                            input logic [1:0] op, input logic [2:0] dt);
    check({tag, ".valid"}, 32'(disp_valid), 32'd1);
    check({tag, ".out1"},  32'(resv_out1),  32'(o1));
    check({tag, ".out2"},  32'(resv_out2),  32'(o2));
    check({tag, ".op"},    32'(OP),         32'(op));
    check({tag, ".tag"},   32'(disp_tag),   32'(dt));
  endtask

  initial begin
    Resetn   = 1'b0;
    fu_ready = 1'b0;
    set_issue(1'b0, 2'd0, 16'h0, 16'h0, 3'd0, 3'd0);
    set_cdb(1'b0, 3'd0, 16'h0);
    repeat (2) step();
    check("rst.disp_valid", 32'(disp_valid), 32'd0);
    check("rst.out1", 32'(resv_out1), 32'd0);
    check("rst.op", 32'(OP), 32'd0);
    check("rst.issue_ready", 32'(issue_ready), 32'd1);
    check("rst.issue_tag", 32'(issue_tag), 32'd1);
    Resetn = 1'b1;
    step();

    // Both operands present: ready after issue edge, dispatch one edge later.
    fu_ready = 1'b1;
    set_issue(1'b1, 2'd1, 16'h0003, 16'h0004, 3'd0, 3'd0);
    check("t1.issue_tag", 32'(issue_tag), 32'd1);
    step();
    set_issue(1'b0, 2'd0, 16'h0, 16'h0, 3'd0, 3'd0);
    check("t1.no_early_disp", 32'(disp_valid), 32'd0);
    check("t1.issue_tag_next", 32'(issue_tag), 32'd2);
    step();
    check_disp("t1.disp", 16'h0003, 16'h0004, 2'd1, 3'd1);
    set_cdb(1'b1, 3'd1, 16'h0099);
    step();
    set_cdb(1'b0, 3'd0, 16'h0);
    check("t1.pulse_end", 32'(disp_valid), 32'd0);
    check("t1.freed_ready", 32'(issue_ready), 32'd1);
    check("t1.freed_tag", 32'(issue_tag), 32'd1);

    // Wait on tag 5, then capture from the CDB.
    set_issue(1'b1, 2'd2, 16'hdead, 16'h0010, 3'd5, 3'd0);
    step();
    set_issue(1'b0, 2'd0, 16'h0, 16'h0, 3'd0, 3'd0);
    step();
    check("t2.waiting", 32'(disp_valid), 32'd0);
    set_cdb(1'b1, 3'd1, 16'h0055);
    step();
    check("t2.own_tag_ignored", 32'(disp_valid), 32'd0);
    set_cdb(1'b1, 3'd5, 16'h0020);
    step();
    set_cdb(1'b0, 3'd0, 16'h0);
    check("t2.capture_edge", 32'(disp_valid), 32'd0);
    step();
    check_disp("t2.disp", 16'h0020, 16'h0010, 2'd2, 3'd1);
    set_cdb(1'b1, 3'd1, 16'h0);
    step();
    set_cdb(1'b0, 3'd0, 16'h0);

    // Same-cycle bypass of both operands.
    set_issue(1'b1, 2'd1, 16'h0000, 16'h0000, 3'd6, 3'd6);
    set_cdb(1'b1, 3'd6, 16'h0007);
    step();
    set_issue(1'b0, 2'd0, 16'h0, 16'h0, 3'd0, 3'd0);
    set_cdb(1'b0, 3'd0, 16'h0);
    check("t3.no_early_disp", 32'(disp_valid), 32'd0);
    step();
    check_disp("t3.disp", 16'h0007, 16'h0007, 2'd1, 3'd1);
    set_cdb(1'b1, 3'd1, 16'h0);
    step();
    set_cdb(1'b0, 3'd0, 16'h0);

    // Fill all entries with the adder stalled.
    fu_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      set_issue(1'b1, 2'(k), 16'(16'h0011 * k), 16'(16'h0100 * k), 3'd0, 3'd0);
      check($sformatf("t4.issue_tag%0d", k), 32'(issue_tag), 32'(k));
      step();
    end
    check("t4.full_ready", 32'(issue_ready), 32'd0);
    check("t4.full_tag", 32'(issue_tag), 32'd0);
    set_issue(1'b1, 2'd3, 16'h0bad, 16'h0bad, 3'd0, 3'd0);
    step();
    set_issue(1'b0, 2'd0, 16'h0, 16'h0, 3'd0, 3'd0);
    check("t4.stalled", 32'(disp_valid), 32'd0);
    fu_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_disp($sformatf("t4.disp%0d", k), 16'(16'h0011 * k), 16'(16'h0100 * k), 2'(k), 3'(k));
    end
    step();
    check("t4.all_exec", 32'(disp_valid), 32'd0);
    check("t4.still_full", 32'(issue_ready), 32'd0);

    // Free entry 1, then issue while entry 0 is released.
    set_cdb(1'b1, 3'd2, 16'h0);
    step();
    check("t5.hole_tag", 32'(issue_tag), 32'd2);
    set_issue(1'b1, 2'd1, 16'h0040, 16'h0041, 3'd0, 3'd0);
    set_cdb(1'b1, 3'd1, 16'h0);
    step();
    set_issue(1'b0, 2'd0, 16'h0, 16'h0, 3'd0, 3'd0);
    set_cdb(1'b0, 3'd0, 16'h0);
    check("t5.freed_ready", 32'(issue_ready), 32'd1);
    check("t5.freed_tag", 32'(issue_tag), 32'd1);
    step();
    check_disp("t5.disp", 16'h0040, 16'h0041, 2'd1, 3'd2);

    // Asynchronous reset with an entry in EXEC and disp_valid high.
    Resetn = 1'b0;
    #1;
    check("t6.async_valid", 32'(disp_valid), 32'd0);
    check("t6.async_out1", 32'(resv_out1), 32'd0);
    check("t6.async_out2", 32'(resv_out2), 32'd0);
    check("t6.async_op", 32'(OP), 32'd0);
    check("t6.async_tag", 32'(disp_tag), 32'd0);
    check("t6.async_ready", 32'(issue_ready), 32'd1);
    check("t6.async_issue_tag", 32'(issue_tag), 32'd1);
    #3;
    Resetn = 1'b1;
    set_cdb(1'b1, 3'd2, 16'h0);
    step();
    set_cdb(1'b0, 3'd0, 16'h0);
    step();
    check("t6.no_spurious", 32'(disp_valid), 32'd0);
    check("t6.empty_tag", 32'(issue_tag), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
